servo_sample_sequencer: RTL
===========================

# servo_sample_sequencer

Sample-loop scheduler for the servo controller. It generates the serial ADC sample clock and chip select, and shifts in one 12-bit conversion per frame, discarding the 4 leading bits. It then triggers the I-PD computation and strobes the PWM update, repeating every frame while `start` is held. It sits between the ADC pins, the I-PD datapath and the PWM generator inside `Servo_Top`.

## Interface
- `CLK_DIV`, 4: `Clock_Nexys` cycles per half period of `Clock_Muestreo` (≥2)
- `LEAD_BITS`, 4: leading ADC bits discarded per frame
- `DATA_W`, 12: ADC data bits per frame, MSB first
- `GAP_SCLK`, 18: `Clock_Muestreo` rising edges spent idle between frames
- `CALC_TIMEOUT`, 255: max `Clock_Nexys` cycles waited for `ctrl_done`

Ports:
- `Clock_Nexys` in 1: system clock. One clock domain; every flop is clocked on its rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `start` in 1: level; enables continuous sampling.
- `data_ADC` in 1: ADC serial data.
- `ctrl_done` in 1: I-PD result valid pulse.
- `CS` out 1: ADC chip select, active low.
- `Clock_Muestreo` out 1: ADC serial clock.
- `adc_data` out `DATA_W`: last captured sample.
- `data_basura` out `LEAD_BITS`: last captured leading bits.
- `adc_valid` out 1: one-cycle strobe, new `adc_data`.
- `ctrl_start` out 1: one-cycle strobe, launches the I-PD.
- `pwm_load` out 1: one-cycle strobe, PWM latches the new duty.
- `busy` out 1: high in any state except IDLE.
- `fault` out 1: sticky; set by a CALC timeout.
- `frame_cnt` out 16: completed frames, wraps at 0xFFFF→0.

## Operation
- Reset values:
  - outputs: `CS`=1, `Clock_Muestreo`=0, `adc_data`=0, `data_basura`=0, `adc_valid`=0, `ctrl_start`=0, `pwm_load`=0, `busy`=0, `fault`=0, `frame_cnt`=0
  - internal: state=IDLE, divider=0, shift register=0
- Divider behaviour:
  - Free-running whenever not in reset.
  - `Clock_Muestreo` toggles when the divider reaches `CLK_DIV-1`; the divider then returns to 0.
  - Internal strobes `rise` and `fall` mark the toggle cycles.
- State IDLE: on `fall` with `start`=1, drive `CS`=0, clear the bit counter, go to CONV.
- State CONV:
  - On each `rise`, shift in `data_ADC`, MSB first, and increment the bit counter.
  - After `LEAD_BITS+DATA_W` (=16) rises, the next `fall` does all of the following in the same cycle:
    - drive `CS`=1
    - load `data_basura` with the first 4 bits and `adc_data` with the last 12 bits
    - pulse `adc_valid` and `ctrl_start`
    - go to CALC
- State CALC:
  - On `ctrl_done`, go to LOAD.
  - If `CALC_TIMEOUT` cycles elapse without `ctrl_done`, set `fault`, skip `pwm_load` and go to GAP.
  - A `ctrl_done` arriving in the same cycle as `ctrl_start` is ignored.
- State LOAD: pulse `pwm_load` for one cycle, increment `frame_cnt`, go to GAP.
- State GAP:
  - Count `GAP_SCLK` rises; the rise counter runs from GAP entry.
  - Then go to IDLE.
  - `ctrl_done` seen outside CALC is ignored.
- `start` sampled only in IDLE. Dropping it mid-frame does not abort: the frame completes through GAP, then the block stays in IDLE.
- `fault` cleared only by `Reset`; sequencing continues normally after a fault.

## Timing
- `CS` transitions coincide with the `Clock_Muestreo` falling-edge cycle.
- `data_ADC` sampled in the `rise` cycle; the ADC changes data on falling edges.
- CS-low window: exactly 16 `Clock_Muestreo` periods (32·`CLK_DIV` cycles).
- `adc_valid` to `ctrl_start`: 0 cycles, same cycle.
- `ctrl_done` to `pwm_load`: 1 cycle.
- Frame period with the default parameters, when `ctrl_done` returns in under `CLK_DIV` cycles: 16+`GAP_SCLK` = 34 sample periods = 272 `Clock_Nexys` cycles, CS fall to CS fall.
- Reset asserted mid-frame forces every reset value immediately (asynchronous). After release, the first frame starts no earlier than the second `fall`.

## Test plan
- Capture: `CLK_DIV`=4; ADC drives 0000 then 12'hA5C. Expect:
  - `CS` low for exactly 128 cycles
  - `adc_data`=12'hA5C, `data_basura`=4'h0
  - one `adc_valid` pulse and one `ctrl_start` pulse
- Done handshake: `ctrl_done` returned 10 cycles after `ctrl_start`. Expect `pwm_load` 11 cycles after `ctrl_start`, `frame_cnt` 0→1.
- Back-to-back frames: `start` held and `ctrl_done` 1 cycle after `ctrl_start`. Expect:
  - CS-fall spacing of 272 cycles
  - 89 frames give `frame_cnt`=89
- Timeout: `ctrl_done` never returned with `CALC_TIMEOUT`=255. Expect:
  - `fault`=1 at cycle 255 after `ctrl_start`
  - no `pwm_load`
  - next frame still starts
- Mid-frame events:
  - `start` dropped at bit 6: the frame completes with correct `adc_data`, then the block holds IDLE.
  - `Reset` pulsed at bit 6: `CS`=1 and `busy`=0 immediately, `adc_data` unchanged from 0.

Source files
------------

// File: rtl/servo_sample_sequencer.sv
// Servo sample-loop scheduler: drives the serial ADC clock and chip select, captures one
// frame per loop, then sequences the I-PD computation and the PWM duty update.
module servo_sample_sequencer #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned LEAD_BITS    = 4,
  parameter int unsigned DATA_W       = 12,
  parameter int unsigned GAP_SCLK     = 18,
  parameter int unsigned CALC_TIMEOUT = 255
) (
  input  logic                 Clock_Nexys,
  input  logic                 Reset,
  input  logic                 start,
  input  logic                 data_ADC,
  input  logic                 ctrl_done,
  output logic                 CS,
  output logic                 Clock_Muestreo,
  output logic [DATA_W-1:0]    adc_data,
  output logic [LEAD_BITS-1:0] data_basura,
  output logic                 adc_valid,
  output logic                 ctrl_start,
  output logic                 pwm_load,
  output logic                 busy,
  output logic                 fault,
  output logic [15:0]          frame_cnt
);

  localparam int unsigned SH_W  = LEAD_BITS + DATA_W;
  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned CNT_W = 16;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SH_LAST  = CNT_W'(SH_W);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(CALC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_SCLK - 1);

  typedef enum logic [2:0] {IDLE, CONV, CALC, LOAD, GAP} state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 sclk_q, sclk_d;
  logic                 arm_q, arm_d;
  logic                 cs_q, cs_d;
  logic [SH_W-1:0]      shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]    adc_data_q, adc_data_d;
  logic [LEAD_BITS-1:0] basura_q, basura_d;
  logic                 adc_valid_q, adc_valid_d;
  logic                 ctrl_start_q, ctrl_start_d;
  logic                 pwm_load_q, pwm_load_d;
  logic                 fault_q, fault_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic                 tick, rise, fall;

  // The first fall after reset only arms the sequencer, so a frame never starts on it.
  always_comb begin
    tick   = (div_q == DIV_LAST);
    div_d  = tick ? '0 : div_q + 1'b1;
    sclk_d = sclk_q ^ tick;
    rise   = tick & ~sclk_q;
    fall   = tick & sclk_q;
    arm_d  = arm_q | fall;
  end

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock_Nexys or posedge Reset) begin
    if (Reset) begin
      div_q        <= '0;
      sclk_q       <= 1'b0;
      arm_q        <= 1'b0;
      state_q      <= IDLE;
      cs_q         <= 1'b1;
      shift_q      <= '0;
      cnt_q        <= '0;
      adc_data_q   <= '0;
      basura_q     <= '0;
      adc_valid_q  <= 1'b0;
      ctrl_start_q <= 1'b0;
      pwm_load_q   <= 1'b0;
      fault_q      <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      div_q        <= div_d;
      sclk_q       <= sclk_d;
      arm_q        <= arm_d;
      state_q      <= state_d;
      cs_q         <= cs_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      adc_data_q   <= adc_data_d;
      basura_q     <= basura_d;
      adc_valid_q  <= adc_valid_d;
      ctrl_start_q <= ctrl_start_d;
      pwm_load_q   <= pwm_load_d;
      fault_q      <= fault_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // NOTE: every next-state signal gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cs_d         = cs_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    adc_data_d   = adc_data_q;
    basura_d     = basura_q;
    fault_d      = fault_q;
    frame_cnt_d  = frame_cnt_q;
    adc_valid_d  = 1'b0;
    ctrl_start_d = 1'b0;
    pwm_load_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fall && start && arm_q) begin
          cs_d    = 1'b0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        if (rise) begin
          shift_d = {shift_q[SH_W-2:0], data_ADC};
          cnt_d   = cnt_q + 1'b1;
        end else if (fall && cnt_q == SH_LAST) begin
          cs_d         = 1'b1;
          adc_data_d   = shift_q[DATA_W-1:0];
          basura_d     = shift_q[SH_W-1 -: LEAD_BITS];
          adc_valid_d  = 1'b1;
          ctrl_start_d = 1'b1;
          cnt_d        = '0;
          state_d      = CALC;
        end
      end
      CALC: begin
        // A done coincident with our own launch strobe belongs to no computation.
        if (ctrl_done && !ctrl_start_q) begin
          pwm_load_d  = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          cnt_d       = '0;
          state_d     = LOAD;
        end else if (cnt_q == TMO_LAST) begin
          fault_d = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = GAP;
      end
      GAP: begin
        if (rise) begin
          if (cnt_q == GAP_LAST) state_d = IDLE;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign CS             = cs_q;
  assign Clock_Muestreo = sclk_q;
  assign adc_data       = adc_data_q;
  assign data_basura    = basura_q;
  assign adc_valid      = adc_valid_q;
  assign ctrl_start     = ctrl_start_q;
  assign pwm_load       = pwm_load_q;
  assign busy           = (state_q != IDLE);
  assign fault          = fault_q;
  assign frame_cnt      = frame_cnt_q;

endmodule
